// File: rtl/bcd_seg7_scan_pkg.sv
// rtl/bcd_seg7_scan_pkg.sv - seven-segment patterns, scan defaults and digit index width
package seg7_pkg;

    localparam int REFRESH_DIV_DEFAULT = 50000;
    localparam int IDX_W               = 2;

    // Active-high patterns, bit 0 = segment a .. bit 6 = segment g
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Non-BCD nibbles show a dash so a corrupted score is visible rather than misread
    function automatic logic [6:0] digit_pattern(input logic [3:0] nibble);
        case (nibble)
            4'd0:    digit_pattern = SEG_0;
            4'd1:    digit_pattern = SEG_1;
            4'd2:    digit_pattern = SEG_2;
            4'd3:    digit_pattern = SEG_3;
            4'd4:    digit_pattern = SEG_4;
            4'd5:    digit_pattern = SEG_5;
            4'd6:    digit_pattern = SEG_6;
            4'd7:    digit_pattern = SEG_7;
            4'd8:    digit_pattern = SEG_8;
            4'd9:    digit_pattern = SEG_9;
            default: digit_pattern = SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/bcd_seg7_scan_if.sv
// rtl/bcd_seg7_scan_if.sv - score input and display output bundle (blink port with SEG7_BLINK_EN)
interface bcd_seg7_scan_if;
    logic [15:0] bcd;
    logic        load;
    logic        lzb_en;
    logic [3:0]  dp_mask;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
`ifdef SEG7_BLINK_EN
    logic        blink;

    modport master (output bcd, load, lzb_en, dp_mask, blink, input seg, dp, an);
    modport slave  (input bcd, load, lzb_en, dp_mask, blink, output seg, dp, an);
`else
    modport master (output bcd, load, lzb_en, dp_mask, input seg, dp, an);
    modport slave  (input bcd, load, lzb_en, dp_mask, output seg, dp, an);
`endif
endinterface

// File: rtl/bcd_seg7_dec.sv
// rtl/bcd_seg7_dec.sv - combinational BCD nibble to active-high segment pattern
module bcd_seg7_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    assign pattern = digit_pattern(nibble);

endmodule

// File: rtl/bcd_seg7_scan.sv
// rtl/bcd_seg7_scan.sv - 4-digit multiplexed seven-segment driver (optional blink: SEG7_BLINK_EN)
module bcd_seg7_scan
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV    = REFRESH_DIV_DEFAULT,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
`ifdef SEG7_BLINK_EN
    ,
    parameter int BLINK_FRAMES   = 250
`endif
) (
    input logic          clk,
    input logic          rst_n,
    bcd_seg7_scan_if.slave bus
);

    localparam int         PW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [3:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

    logic [PW-1:0]    presc;
    logic [IDX_W-1:0] idx;
    logic [15:0]      shadow;
    logic             slot_wrap;
    logic [3:0]       digit [4];
    logic [3:0]       zero;
    logic [3:0]       lead_zero;
    logic [6:0]       pattern;
    logic             blank;
    logic             off;
    logic [6:0]       seg_h;
    logic             dp_h;
    logic [3:0]       an_h;

    assign slot_wrap = (presc == PW'(REFRESH_DIV - 1));

    // Prescaler: one digit slot every REFRESH_DIV cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            presc <= '0;
        else if (slot_wrap)
            presc <= '0;
        else
            presc <= presc + 1'b1;
    end

    // Digit index walks 0..3 and wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idx <= '0;
        else if (slot_wrap)
            idx <= idx + 1'b1;
    end

    // Shadow register only follows bcd on load strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            shadow <= '0;
        else if (bus.load)
            shadow <= bus.bcd;
    end

    assign digit[0] = shadow[3:0];
    assign digit[1] = shadow[7:4];
    assign digit[2] = shadow[11:8];
    assign digit[3] = shadow[15:12];

    // A digit is a leading zero when it and every higher digit are exactly zero;
    // invalid nibbles are non-zero so they stop the blanking chain
    assign zero         = {digit[3] == 4'd0, digit[2] == 4'd0, digit[1] == 4'd0, digit[0] == 4'd0};
    assign lead_zero[3] = zero[3];
    assign lead_zero[2] = zero[3] & zero[2];
    assign lead_zero[1] = zero[3] & zero[2] & zero[1];
    assign lead_zero[0] = 1'b0;

    bcd_seg7_dec u_dec (
        .nibble  (digit[idx]),
        .pattern (pattern)
    );

    assign blank = bus.lzb_en & lead_zero[idx];

`ifdef SEG7_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] frame_cnt;
    logic          phase;

    // Frame counter flips the blink phase every BLINK_FRAMES full scans
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (slot_wrap && idx == 2'd3) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign off = bus.blink & phase;
`else
    assign off = 1'b0;
`endif

    // Active-high view of the current slot; a blanked slot keeps its anode only to show a dp
    always_comb begin
        seg_h = pattern;
        dp_h  = bus.dp_mask[idx];
        an_h  = 4'b0001 << idx;
        if (blank) begin
            seg_h = SEG_BLANK;
            if (!bus.dp_mask[idx])
                an_h = 4'b0000;
        end
        if (off) begin
            seg_h = SEG_BLANK;
            dp_h  = 1'b0;
            an_h  = 4'b0000;
        end
    end

    // Output register applies board polarity; reset parks everything dark
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.seg <= SEG_OFF;
            bus.dp  <= DP_OFF;
            bus.an  <= AN_OFF;
        end else begin
            bus.seg <= seg_h ^ SEG_OFF;
            bus.dp  <= dp_h ^ DP_OFF;
            bus.an  <= an_h ^ AN_OFF;
        end
    end

endmodule
